// File: rtl/rtc_pkg.sv
// Shared definitions for the RTC frame loader: FSM states, byte slot indices
// and the BCD digit check.
package rtc_pkg;

    // Bytes in one RTC burst.
    localparam int unsigned RTC_N_BYTES = 8;
    // Width of a byte-slot index (covers the 8-byte burst).
    localparam int unsigned IDX_W = 3;

    // Byte slot order as delivered by the RTC read engine.
    localparam int unsigned IDX_SEG   = 0;
    localparam int unsigned IDX_MIN   = 1;
    localparam int unsigned IDX_HORA  = 2;
    localparam int unsigned IDX_FECHA = 3;
    localparam int unsigned IDX_MES   = 4;
    localparam int unsigned IDX_ANIO  = 5;
    localparam int unsigned IDX_DIA   = 6;
    localparam int unsigned IDX_SEM   = 7;

    typedef enum logic [1:0] {
        StIdle,
        StWaitLat,
        StCapture,
        StPend
    } rtc_state_e;

    // True when either nibble is not a decimal digit.
    function automatic logic bcd_bad(input logic [7:0] b);
        return (b[7:4] > 4'd9) || (b[3:0] > 4'd9);
    endfunction

endpackage

// File: rtl/rtc_byte_bank.sv
// N_BYTES x 8 register file: single-byte write, whole-bank parallel load,
// registered read port and a flat view of all bytes.
module rtc_byte_bank
    import rtc_pkg::*;
#(
    parameter int unsigned N_BYTES = RTC_N_BYTES
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 we_i,
    input  logic [IDX_W-1:0]     waddr_i,
    input  logic [7:0]           wdata_i,
    input  logic                 load_i,
    input  logic [N_BYTES*8-1:0] load_data_i,
    input  logic [IDX_W-1:0]     raddr_i,
    output logic [7:0]           rdata_o,
    output logic [N_BYTES*8-1:0] bytes_o
);

    logic [7:0] mem_q [N_BYTES];
    logic [7:0] rdata_q;

    // Storage update; a bulk load takes priority over a single-byte write.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int unsigned i = 0; i < N_BYTES; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else if (load_i) begin
            for (int unsigned i = 0; i < N_BYTES; i++) begin
                mem_q[i] <= load_data_i[i*8 +: 8];
            end
        end else if (we_i && (32'(waddr_i) < N_BYTES)) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Registered read; out-of-range addresses read as zero. Sees the value
    // held before any same-cycle write or load.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rdata_q <= 8'h00;
        end else if (32'(raddr_i) < N_BYTES) begin
            rdata_q <= mem_q[raddr_i];
        end else begin
            rdata_q <= 8'h00;
        end
    end

    // Flatten the bank for a parallel transfer into another bank.
    always_comb begin
        bytes_o = '0;
        for (int unsigned i = 0; i < N_BYTES; i++) begin
            bytes_o[i*8 +: 8] = mem_q[i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/rtc_frame_loader.sv
// Captures each RTC byte burst into a shadow bank and commits it to the
// display bank only on a frame tick, so the renderer never sees a half
// updated date/time.
module rtc_frame_loader
    import rtc_pkg::*;
#(
    parameter int unsigned N_BYTES   = RTC_N_BYTES,
    parameter int unsigned START_LAT = 1,
    parameter int unsigned CHECK_BCD = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       inicioSecuencia,
    input  logic [7:0] datoRTC,
    input  logic       frame_tick,
    input  logic [2:0] rd_addr,
    output logic [7:0] rd_data,
    output logic       busy,
    output logic       pend,
    output logic       commit,
    output logic       overrun,
    output logic       bad_frame,
    input  logic       clr_flags
);

    localparam int unsigned LAT_W = (START_LAT > 1) ? $clog2(START_LAT) : 1;
    // With a one-cycle latency byte 0 follows the start edge directly.
    localparam rtc_state_e StStart = (START_LAT == 1) ? StCapture : StWaitLat;

    rtc_state_e       state_q;
    logic             inicio_prev_q;
    logic [LAT_W-1:0] lat_q;
    logic [IDX_W-1:0] idx_q;
    logic             err_q;
    logic             busy_q;
    logic             pend_q;
    logic             commit_q;
    logic             overrun_q;
    logic             bad_q;

    logic start_acc;
    logic last_byte;
    logic byte_err;
    logic burst_bad;
    logic shadow_we;
    logic disp_load;

    logic [N_BYTES*8-1:0] shadow_bytes;
    logic [N_BYTES*8-1:0] unused_disp_bytes;
    logic [7:0]           unused_shadow_rd;

    // Start-edge detect, burst bookkeeping and bank control strobes.
    always_comb begin
        start_acc = inicioSecuencia & ~inicio_prev_q;
        last_byte = (32'(idx_q) == N_BYTES - 1);
        byte_err  = (CHECK_BCD != 0) && bcd_bad(datoRTC);
        // Includes the byte being captured now, so the verdict needs no extra cycle.
        burst_bad = err_q | byte_err;
        shadow_we = (state_q == StCapture);
        disp_load = (state_q == StPend) && frame_tick;
    end

    // Sequencer FSM with registered status outputs and sticky flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            inicio_prev_q <= 1'b0;
            lat_q         <= '0;
            idx_q         <= '0;
            err_q         <= 1'b0;
            busy_q        <= 1'b0;
            pend_q        <= 1'b0;
            commit_q      <= 1'b0;
            overrun_q     <= 1'b0;
            bad_q         <= 1'b0;
        end else begin
            inicio_prev_q <= inicioSecuencia;
            commit_q      <= 1'b0;
            // Clear first so a set later in this block wins.
            if (clr_flags) begin
                overrun_q <= 1'b0;
                bad_q     <= 1'b0;
            end
            unique case (state_q)
                StIdle: begin
                    if (start_acc) begin
                        state_q <= StStart;
                        lat_q   <= LAT_W'(START_LAT - 1);
                        idx_q   <= '0;
                        err_q   <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                StWaitLat: begin
                    // lat_q counts the wait cycles still to go, this one included.
                    if (lat_q <= LAT_W'(1)) begin
                        state_q <= StCapture;
                        idx_q   <= '0;
                    end else begin
                        lat_q <= lat_q - LAT_W'(1);
                    end
                end
                StCapture: begin
                    idx_q <= idx_q + IDX_W'(1);
                    err_q <= burst_bad;
                    if (last_byte) begin
                        busy_q <= 1'b0;
                        if (burst_bad) begin
                            state_q <= StIdle;
                            bad_q   <= 1'b1;
                        end else begin
                            state_q <= StPend;
                            pend_q  <= 1'b1;
                        end
                    end
                end
                StPend: begin
                    if (frame_tick) begin
                        commit_q <= 1'b1;
                        pend_q   <= 1'b0;
                        state_q  <= StIdle;
                    end
                    if (start_acc) begin
                        // Without a tick the pending burst is lost.
                        if (!frame_tick) begin
                            overrun_q <= 1'b1;
                        end
                        state_q <= StStart;
                        lat_q   <= LAT_W'(START_LAT - 1);
                        idx_q   <= '0;
                        err_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        pend_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                    pend_q  <= 1'b0;
                end
            endcase
        end
    end

    rtc_byte_bank #(
        .N_BYTES (N_BYTES)
    ) u_shadow (
        .clk_i       (clk),
        .reset_i     (reset),
        .we_i        (shadow_we),
        .waddr_i     (idx_q),
        .wdata_i     (datoRTC),
        .load_i      (1'b0),
        .load_data_i ('0),
        .raddr_i     ('0),
        .rdata_o     (unused_shadow_rd),
        .bytes_o     (shadow_bytes)
    );

    rtc_byte_bank #(
        .N_BYTES (N_BYTES)
    ) u_display (
        .clk_i       (clk),
        .reset_i     (reset),
        .we_i        (1'b0),
        .waddr_i     ('0),
        .wdata_i     (8'h00),
        .load_i      (disp_load),
        .load_data_i (shadow_bytes),
        .raddr_i     (rd_addr),
        .rdata_o     (rd_data),
        .bytes_o     (unused_disp_bytes)
    );

    assign busy      = busy_q;
    assign pend      = pend_q;
    assign commit    = commit_q;
    assign overrun   = overrun_q;
    assign bad_frame = bad_q;

endmodule

// File: tb/tb_rtc_frame_loader.sv
// Self-checking bench for rtc_frame_loader (START_LAT=1, CHECK_BCD=1).
module tb_rtc_frame_loader;

    logic       clk = 1'b0;
    logic       reset;
    logic       inicioSecuencia;
    logic [7:0] datoRTC;
    logic       frame_tick;
    logic [2:0] rd_addr;
    logic [7:0] rd_data;
    logic       busy;
    logic       pend;
    logic       commit;
    logic       overrun;
    logic       bad_frame;
    logic       clr_flags;

    int         n_cmp = 0;
    int         n_err = 0;
    int         busy_cnt;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    rtc_frame_loader #(
        .N_BYTES   (8),
        .START_LAT (1),
        .CHECK_BCD (1)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .inicioSecuencia (inicioSecuencia),
        .datoRTC         (datoRTC),
        .frame_tick      (frame_tick),
        .rd_addr         (rd_addr),
        .rd_data         (rd_data),
        .busy            (busy),
        .pend            (pend),
        .commit          (commit),
        .overrun         (overrun),
        .bad_frame       (bad_frame),
        .clr_flags       (clr_flags)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Push the expected byte, let the registered read complete, pop and compare.
    task automatic rd(input logic [2:0] a, input logic [7:0] e);
        rd_addr = a;
        exp_q.push_back(e);
        cyc();
        check_eq($sformatf("rd[%0d]", a), rd_data, exp_q.pop_front());
    endtask

    task automatic start_edge();
        inicioSecuencia = 1'b1;
        cyc();
        inicioSecuencia = 1'b0;
    endtask

    // Byte i of the burst is bv[8*i +: 8] (byte 0 in the low bits).
    task automatic feed(input logic [63:0] bv);
        for (int i = 0; i < 8; i++) begin
            datoRTC = bv[8*i +: 8];
            cyc();
        end
        datoRTC = 8'h00;
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        inicioSecuencia = 1'b0;
        datoRTC = 8'h00;
        frame_tick = 1'b0;
        rd_addr = 3'd0;
        clr_flags = 1'b0;
        cyc();
        cyc();
        reset = 1'b0;

        // Reset state.
        check_eq("rst busy", busy, 1'b0);
        check_eq("rst pend", pend, 1'b0);
        check_eq("rst commit", commit, 1'b0);
        check_eq("rst overrun", overrun, 1'b0);
        check_eq("rst bad", bad_frame, 1'b0);
        for (int i = 0; i < 8; i++) rd(3'(i), 8'h00);

        // Basic burst, held pending until frame_tick.
        start_edge();
        feed(64'h04_05_17_12_23_03_04_24);
        check_eq("b1 pend", pend, 1'b1);
        check_eq("b1 busy", busy, 1'b0);
        check_eq("b1 commit early", commit, 1'b0);
        cyc(); cyc(); cyc();
        check_eq("b1 wait commit", commit, 1'b0);
        check_eq("b1 wait pend", pend, 1'b1);
        tick();
        check_eq("b1 commit", commit, 1'b1);
        check_eq("b1 pend clr", pend, 1'b0);
        cyc();
        check_eq("b1 commit once", commit, 1'b0);
        rd(3'd0, 8'h24);
        rd(3'd5, 8'h17);

        // Start held high for 20 cycles gives a single burst.
        inicioSecuencia = 1'b1;
        cyc();
        busy_cnt = int'(busy);
        for (int i = 0; i < 19; i++) begin
            datoRTC = (i < 8) ? 8'(8'h40 + i) : 8'h11;
            cyc();
            busy_cnt += int'(busy);
        end
        inicioSecuencia = 1'b0;
        datoRTC = 8'h00;
        cyc();
        check_eq("hold busy cycles", busy_cnt, 8);
        check_eq("hold pend", pend, 1'b1);
        check_eq("hold overrun", overrun, 1'b0);
        tick();
        check_eq("hold commit", commit, 1'b1);
        rd(3'd3, 8'h43);
        rd(3'd7, 8'h47);

        // Overrun: a second burst replaces the pending one.
        start_edge();
        feed(64'h08_07_06_05_04_03_02_01);
        check_eq("ov first pend", pend, 1'b1);
        start_edge();
        check_eq("ov flag", overrun, 1'b1);
        check_eq("ov busy", busy, 1'b1);
        feed(64'h37_36_35_34_33_32_31_30);
        check_eq("ov second pend", pend, 1'b1);
        check_eq("ov sticky", overrun, 1'b1);
        // Read issued in the commit cycle returns the old byte.
        rd_addr = 3'd1;
        exp_q.push_back(8'h41);
        tick();
        check_eq("ov commit", commit, 1'b1);
        check_eq("rd commit-cycle old", rd_data, exp_q.pop_front());
        exp_q.push_back(8'h31);
        cyc();
        check_eq("rd after commit new", rd_data, exp_q.pop_front());
        rd(3'd2, 8'h32);
        clr_flags = 1'b1;
        cyc();
        clr_flags = 1'b0;
        check_eq("ov cleared", overrun, 1'b0);

        // frame_tick and a new start on the same PEND cycle.
        start_edge();
        feed(64'h18_17_16_15_14_13_12_11);
        frame_tick = 1'b1;
        inicioSecuencia = 1'b1;
        cyc();
        frame_tick = 1'b0;
        inicioSecuencia = 1'b0;
        check_eq("sim commit", commit, 1'b1);
        check_eq("sim busy", busy, 1'b1);
        check_eq("sim overrun", overrun, 1'b0);
        feed(64'h28_27_26_25_24_23_22_21);
        check_eq("sim pend", pend, 1'b1);
        check_eq("sim overrun after", overrun, 1'b0);
        tick();
        rd(3'd0, 8'h21);
        rd(3'd4, 8'h25);

        // BCD failure mid-burst.
        start_edge();
        feed(64'h04_05_06_07_08_0C_02_01);
        check_eq("bcd bad", bad_frame, 1'b1);
        check_eq("bcd pend", pend, 1'b0);
        check_eq("bcd busy", busy, 1'b0);
        tick();
        check_eq("idle tick commit", commit, 1'b0);
        rd(3'd0, 8'h21);
        rd(3'd2, 8'h23);
        clr_flags = 1'b1;
        cyc();
        clr_flags = 1'b0;
        check_eq("bcd cleared", bad_frame, 1'b0);

        // BCD failure on the last byte, with clr_flags on that same cycle.
        start_edge();
        for (int i = 0; i < 8; i++) begin
            datoRTC = (i == 7) ? 8'h9A : 8'(i);
            clr_flags = (i == 7);
            cyc();
        end
        clr_flags = 1'b0;
        datoRTC = 8'h00;
        check_eq("bcd last bad", bad_frame, 1'b1);
        check_eq("bcd last pend", pend, 1'b0);
        clr_flags = 1'b1;
        cyc();
        clr_flags = 1'b0;
        check_eq("bcd last cleared", bad_frame, 1'b0);

        // Reset in the middle of a capture clears everything.
        start_edge();
        datoRTC = 8'h55;
        cyc(); cyc(); cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        check_eq("mid rst busy", busy, 1'b0);
        check_eq("mid rst pend", pend, 1'b0);
        rd(3'd0, 8'h00);
        rd(3'd4, 8'h00);
        start_edge();
        feed(64'h59_58_57_56_55_54_53_52);
        tick();
        rd(3'd7, 8'h59);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rtc_frame_loader.md
Name: rtc_frame_loader

Overview:
Sequencer that captures the burst of RTC bytes on datoRTC after each inicioSecuencia into a shadow bank. It commits the captured set atomically to a display bank only at a frame boundary, so the VGA text renderer never shows a half-updated date/time. It sits between the RTC read engine and the Interfaz renderer. The renderer reads committed bytes through a registered read port.

Parameters:
N_BYTES, 8, bytes per burst (seg, min, hora, fecha, mes, año, dia, semana), index 0..N_BYTES-1.
START_LAT, 1, cycles from the accepted inicioSecuencia edge to byte 0 on datoRTC (≥1).
CHECK_BCD, 0, when 1, any captured byte with a nibble >9 marks the burst bad; a bad burst is never committed.

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high
inicioSecuencia  in  1  burst-start level from the RTC engine; rising edge only is used
datoRTC  in  8  RTC byte, one per cycle during the burst
frame_tick  in  1  one-cycle pulse at start of vertical blanking
rd_addr  in  3  display-bank index
rd_data  out  8  display-bank byte, registered
busy  out  1  high in WAIT_LAT and CAPTURE
pend  out  1  high while a complete good burst awaits frame_tick
commit  out  1  one-cycle pulse on the cycle the display bank is updated
overrun  out  1  sticky; set when a pending burst is discarded by a new start
bad_frame  out  1  sticky; set when a burst fails the BCD check
clr_flags  in  1  clears overrun and bad_frame (reset-like, same cycle)

Behaviour:
- Reset: state IDLE; shadow and display banks all 0x00; rd_data=0; busy=pend=commit=overrun=bad_frame=0; edge detector previous value=0.
- Start edge: start_acc = inicioSecuencia & ~prev. Holding inicioSecuencia high gives exactly one edge.
- States:
  - IDLE: start_acc → WAIT_LAT with latency counter = START_LAT-1. If START_LAT=1, go directly to CAPTURE with idx=0.
  - WAIT_LAT: count down; at 0 → CAPTURE with idx=0.
  - CAPTURE: each cycle shadow[idx] ← datoRTC and idx++. After idx=N_BYTES-1 is written → PEND (or IDLE with bad_frame set if the burst failed BCD). start_acc during WAIT_LAT or CAPTURE is ignored.
  - PEND: frame_tick → display ← shadow (all bytes in one cycle), commit=1 that cycle, → IDLE. start_acc without frame_tick → overrun=1, pending burst dropped, → WAIT_LAT/CAPTURE.
- Simultaneous events:
  - frame_tick on the last CAPTURE cycle does not commit; commit waits for the next frame_tick.
  - frame_tick and start_acc on the same PEND cycle: commit first, then the new start is accepted (→ WAIT_LAT/CAPTURE). overrun is not set.
  - clr_flags together with a set condition: the set wins.
- Read port: rd_data ← display[rd_addr] with 1-cycle latency. rd_addr ≥ N_BYTES returns 0x00. The display bank is unchanged except on commit. A read in the commit cycle returns the old value; the new value appears the following cycle.
- BCD check (CHECK_BCD=1): a per-burst error bit is ORed per byte. It is evaluated after the last byte, with no extra cycle.
- frame_tick outside PEND has no effect.
- reset mid-capture: all state is cleared as on power-up. The display bank returns to 0x00.

Decomposition:
- Shared package rtc_pkg holds:
  - state encoding (IDLE, WAIT_LAT, CAPTURE, PEND)
  - byte index constants IDX_SEG=0, IDX_MIN=1, IDX_HORA=2, IDX_FECHA=3, IDX_MES=4, IDX_ANIO=5, IDX_DIA=6, IDX_SEM=7
  - N_BYTES default
- One natural sub-module, rtc_byte_bank: an N_BYTES×8 register file with a per-index write, a bulk load from a parallel input, and a registered read. It is instantiated twice (shadow, display).

Test Plan:
- Reset, then rd_addr sweep 0..7 → rd_data=0x00 each; all flags 0.
- inicioSecuencia rises, bytes 0x24,0x04,0x03,0x23,0x12,0x17,0x05,0x04 follow from next cycle → pend=1 after 8th byte; no commit until frame_tick; after frame_tick commit pulses once and rd_addr=0/5 read 0x24/0x17.
- inicioSecuencia held high 20 cycles → exactly one burst captured; busy high 8 cycles.
- Second burst (0x30..) completes while first pending, no frame_tick → overrun=1; next frame_tick commits the second burst only.
- frame_tick and new start edge on same PEND cycle → commit=1, busy=1 next cycle, overrun stays 0.
- CHECK_BCD=1, burst containing 0x0C → bad_frame=1, pend never asserted, display unchanged; clr_flags → bad_frame=0.
